prog_load_run_ctrl: RTL and testbench

- Sequencer for one RISC-V core and its shared instruction/data BRAM.
- Owns the BRAM data port (port A) and the core reset.
- Streams a program image from a host word stream into BRAM, releases the core after a fixed reset-hold delay, muxes port A to the core while it runs, and detects completion (a store to DONE_ADDR) or timeout.
- Reports the cycle count and the result word.

---
 rtl/prog_load_run_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_prog_load_run_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_run_ctrl.sv
// prog_load_run_ctrl
// Sequencer for one RISC-V core sharing an instruction/data BRAM. Streams a program image from
// a host word stream into BRAM port A, holds the core in reset for RST_HOLD cycles, then hands
// port A to the core and watches for a store to DONE_ADDR (completion) or a cycle-budget timeout.
//
// Ports:
//   clk_i           single clock
//   rst_ni          synchronous active-low reset
//   start_i         one-cycle start pulse (honoured in IDLE/DONE/TOUT only)
//   load_len_i      words to load; 0 runs the preloaded image
//   s_valid_i/s_data_i/s_ready_o   host word stream
//   core_addr_i/core_wr_data_i/core_wr_en_i/core_rd_data_o   core data-memory port
//   bram_addr_o/bram_wr_data_o/bram_wr_en_o/bram_rd_data_i   BRAM port A
//   core_reset_o    registered active-high core reset
//   busy_o          LOAD, RELEASE or RUN
//   done_o/timeout_o  sticky status flags
//   cycle_count_o   RUN cycles elapsed (saturating)
//   result_o        data of the completing store
module prog_load_run_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NB_COL = 4,
    parameter logic [ADDR_WIDTH-1:0] DONE_ADDR = 10'h3FF,
    parameter int unsigned RST_HOLD = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2**24,
    parameter int unsigned CYC_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   load_len_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    input  logic [13:0]           core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wr_data_i,
    input  logic [NB_COL-1:0]     core_wr_en_i,
    output logic [DATA_WIDTH-1:0] core_rd_data_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_wr_data_o,
    output logic [NB_COL-1:0]     bram_wr_en_o,
    input  logic [DATA_WIDTH-1:0] bram_rd_data_i,
    output logic                  core_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [CYC_W-1:0]      cycle_count_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [LEN_W-1:0] MEM_WORDS = LEN_W'(2**ADDR_WIDTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_TOUT    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [LEN_W-1:0]      ptr_q, ptr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  core_reset_q, core_reset_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  beat;
    logic                  complete;
    logic [CYC_W-1:0]      cyc_inc;
    logic [LEN_W-1:0]      len_clamped;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^core_addr_i[13:ADDR_WIDTH];

    assign beat        = (state_q == ST_LOAD) && s_valid_i;
    assign complete    = (core_wr_en_i != '0) && (core_addr_i[ADDR_WIDTH-1:0] == DONE_ADDR);
    assign cyc_inc     = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
    assign len_clamped = (load_len_i > MEM_WORDS) ? MEM_WORDS : load_len_i;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        hold_d    = hold_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cyc_d     = cyc_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TOUT: begin
                if (start_i) begin
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cyc_d     = '0;
                    result_d  = '0;
                    ptr_d     = '0;
                    hold_d    = '0;
                    len_d     = len_clamped;
                    state_d   = (load_len_i == '0) ? ST_RELEASE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    ptr_d = ptr_q + LEN_W'(1);
                    if (ptr_q == len_q - LEN_W'(1)) begin
                        hold_d  = '0;
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                cyc_d = cyc_inc;
                // Completion takes priority over a coincident timeout.
                if (complete) begin
                    result_d = core_wr_data_i;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (cyc_inc == CYC_W'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_TOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Core runs only while RUN is the registered state, so reset drops on the first RUN cycle.
    assign core_reset_d = (state_d != ST_RUN);

    always_comb begin
        bram_addr_o    = '0;
        bram_wr_data_o = '0;
        bram_wr_en_o   = '0;
        case (state_q)
            ST_LOAD: begin
                bram_addr_o    = ptr_q[ADDR_WIDTH-1:0];
                bram_wr_data_o = s_data_i;
                bram_wr_en_o   = beat ? '1 : '0;
            end
            ST_RUN: begin
                bram_addr_o    = core_addr_i[ADDR_WIDTH-1:0];
                bram_wr_data_o = core_wr_data_i;
                bram_wr_en_o   = core_wr_en_i;
            end
            default: ;
        endcase
        if (!rst_ni) begin
            bram_wr_en_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            len_q        <= '0;
            hold_q       <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cyc_q        <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            hold_q       <= hold_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            cyc_q        <= cyc_d;
            result_q     <= result_d;
        end
    end

    assign s_ready_o      = (state_q == ST_LOAD);
    assign busy_o         = (state_q == ST_LOAD) || (state_q == ST_RELEASE) || (state_q == ST_RUN);
    assign core_reset_o   = core_reset_q;
    assign done_o         = done_q;
    assign timeout_o      = timeout_q;
    assign cycle_count_o  = cyc_q;
    assign result_o       = result_q;
    assign core_rd_data_o = bram_rd_data_i;

endmodule

// File: tb/tb_prog_load_run_ctrl.sv
// Bench for prog_load_run_ctrl: table of program runs, hand sequences for backpressure and
// reset mid-load, then randomized runs checked against a per-run reference model.
module tb_prog_load_run_ctrl;

    localparam int T = 128;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [10:0] load_len_i;
    logic        s_valid_i;
    logic [31:0] s_data_i;
    logic        s_ready_o;
    logic [13:0] core_addr_i;
    logic [31:0] core_wr_data_i;
    logic [3:0]  core_wr_en_i;
    logic [31:0] core_rd_data_o;
    logic [9:0]  bram_addr_o;
    logic [31:0] bram_wr_data_o;
    logic [3:0]  bram_wr_en_o;
    logic [31:0] bram_rd_data_i;
    logic        core_reset_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] cycle_count_o;
    logic [31:0] result_o;

    int n_vec = 0;
    int n_err = 0;
    bit vq[$];

    always #5 clk_i = ~clk_i;

    prog_load_run_ctrl #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .load_len_i     (load_len_i),
        .s_valid_i      (s_valid_i),
        .s_data_i       (s_data_i),
        .s_ready_o      (s_ready_o),
        .core_addr_i    (core_addr_i),
        .core_wr_data_i (core_wr_data_i),
        .core_wr_en_i   (core_wr_en_i),
        .core_rd_data_o (core_rd_data_o),
        .bram_addr_o    (bram_addr_o),
        .bram_wr_data_o (bram_wr_data_o),
        .bram_wr_en_o   (bram_wr_en_o),
        .bram_rd_data_i (bram_rd_data_i),
        .core_reset_o   (core_reset_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .timeout_o      (timeout_o),
        .cycle_count_o  (cycle_count_o),
        .result_o       (result_o)
    );

    typedef struct {
        int          len;
        int          done_at;   // RUN cycle of the completing store, 0 = never
        int          pat;       // 1: words 0x11, 0x22, ...
        int          gap;       // percent of idle host cycles
        int          srun;      // RUN cycle to pulse a stray start, 0 = none
        logic [31:0] res;
        int          exp_w;
        int          exp_cnt;
        bit          exp_done;
        bit          exp_to;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clk_step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic run_prog(input int len, input int done_at, input int pat, input int gap,
                            input int srun, input logic [31:0] res_word, input int exp_w,
                            input int exp_cnt, input bit exp_done, input bit exp_to);
        int eff, beats, c;
        logic [31:0] exp_res;
        eff     = (len > 1024) ? 1024 : len;
        exp_res = exp_done ? res_word : 32'h0;

        start_i      = 1'b1;
        load_len_i   = 11'(len);
        s_valid_i    = 1'b0;
        core_wr_en_i = 4'h0;
        clk_step();
        start_i    = 1'b0;
        load_len_i = '0;
        chk("start_clr_done", done_o, 0);
        chk("start_clr_timeout", timeout_o, 0);
        chk("start_clr_count", cycle_count_o, 0);
        chk("start_clr_result", result_o, 0);
        chk("start_busy", busy_o, 1);

        beats = 0;
        c     = 0;
        while (beats < eff && c < 4 * eff + 100) begin
            if (vq.size() > 0) s_valid_i = vq.pop_front();
            else s_valid_i = ($urandom_range(0, 99) >= gap);
            s_data_i       = pat ? 32'(32'h11 * (beats + 1)) : $urandom;
            bram_rd_data_i = $urandom;
            #1;
            chk("load_ready", s_ready_o, 1);
            chk("load_core_reset", core_reset_o, 1);
            chk("rd_passthrough", core_rd_data_o, bram_rd_data_i);
            if (s_valid_i) begin
                chk("load_we", bram_wr_en_o, 4'hF);
                chk("load_addr", bram_addr_o, 64'(beats));
                chk("load_data", bram_wr_data_o, s_data_i);
                beats++;
            end else begin
                chk("gap_we", bram_wr_en_o, 0);
            end
            clk_step();
            c++;
        end
        chk("load_beats", 64'(beats), 64'(exp_w));

        // Host keeps offering and core drives stores while held: nothing may reach BRAM.
        s_valid_i    = 1'b1;
        core_addr_i  = 14'($urandom);
        core_wr_en_i = 4'hF;
        c = 0;
        while (core_reset_o && c < 40) begin
            #1;
            chk("rel_ready", s_ready_o, 0);
            chk("rel_we", bram_wr_en_o, 0);
            chk("rel_busy", busy_o, 1);
            clk_step();
            c++;
        end
        chk("hold_cycles", 64'(c), 8);
        s_valid_i = 1'b0;

        for (int k = 1; k <= T + 2; k++) begin
            if (k == done_at) begin
                core_addr_i    = {4'($urandom), 10'h3FF};
                core_wr_en_i   = 4'hF;
                core_wr_data_i = res_word;
            end else begin
                core_addr_i    = {4'($urandom), 10'($urandom_range(0, 1022))};
                core_wr_en_i   = 4'($urandom);
                core_wr_data_i = $urandom;
            end
            start_i        = (k == srun);
            load_len_i     = 11'd3;
            bram_rd_data_i = $urandom;
            #1;
            chk("run_core_reset", core_reset_o, 0);
            chk("run_busy", busy_o, 1);
            chk("run_addr", bram_addr_o, core_addr_i[9:0]);
            chk("run_we", bram_wr_en_o, core_wr_en_i);
            chk("run_data", bram_wr_data_o, core_wr_data_i);
            chk("run_rd", core_rd_data_o, bram_rd_data_i);
            clk_step();
            start_i    = 1'b0;
            load_len_i = '0;
            if (k == done_at || k == T) break;
        end

        core_wr_en_i = 4'hF;
        #1;
        chk("end_done", done_o, 64'(exp_done));
        chk("end_timeout", timeout_o, 64'(exp_to));
        chk("end_count", cycle_count_o, 64'(exp_cnt));
        chk("end_result", result_o, exp_res);
        chk("end_core_reset", core_reset_o, 1);
        chk("end_busy", busy_o, 0);
        chk("end_we", bram_wr_en_o, 0);
        core_wr_en_i = 4'h0;
    endtask

    initial begin
        tbl[0] = '{4, 100, 1, 0, 0, 32'hCAFE0001, 4, 100, 1'b1, 1'b0};
        tbl[1] = '{0, 0, 0, 0, 3, 32'h0, 0, T, 1'b0, 1'b1};
        tbl[2] = '{2, T, 0, 0, 0, 32'hCAFE0002, 2, T, 1'b1, 1'b0};
        tbl[3] = '{2047, 5, 0, 0, 0, 32'hCAFE0003, 1024, 5, 1'b1, 1'b0};
        tbl[4] = '{1024, 0, 0, 30, 0, 32'h0, 1024, T, 1'b0, 1'b1};
        tbl[5] = '{1, 1, 0, 0, 0, 32'hCAFE0005, 1, 1, 1'b1, 1'b0};
        tbl[6] = '{7, 30, 0, 50, 10, 32'hCAFE0006, 7, 30, 1'b1, 1'b0};

        rst_ni         = 1'b0;
        start_i        = 1'b0;
        load_len_i     = '0;
        s_valid_i      = 1'b1;
        s_data_i       = '0;
        core_addr_i    = 14'h3FF;
        core_wr_data_i = '0;
        core_wr_en_i   = 4'hF;
        bram_rd_data_i = '0;
        repeat (3) clk_step();
        #1;
        chk("rst_core_reset", core_reset_o, 1);
        chk("rst_ready", s_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_count", cycle_count_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_we", bram_wr_en_o, 0);
        rst_ni       = 1'b1;
        s_valid_i    = 1'b0;
        core_wr_en_i = 4'h0;
        clk_step();

        for (int i = 0; i < 7; i++) begin
            run_prog(tbl[i].len, tbl[i].done_at, tbl[i].pat, tbl[i].gap, tbl[i].srun,
                     tbl[i].res, tbl[i].exp_w, tbl[i].exp_cnt, tbl[i].exp_done, tbl[i].exp_to);
        end

        // Backpressure: valid pattern 1,0,1,0,0,1 writes addresses 0,1,2 only.
        vq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        run_prog(3, 10, 0, 0, 0, 32'h0BAD0010, 3, 10, 1'b1, 1'b0);
        chk("bp_pattern_consumed", 64'(vq.size()), 0);

        // Reset low in LOAD after two beats.
        start_i    = 1'b1;
        load_len_i = 11'd5;
        clk_step();
        start_i    = 1'b0;
        load_len_i = '0;
        for (int i = 0; i < 2; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = $urandom;
            clk_step();
        end
        rst_ni = 1'b0;
        #1;
        chk("midrst_we", bram_wr_en_o, 0);
        clk_step();
        rst_ni    = 1'b1;
        s_valid_i = 1'b0;
        #1;
        chk("midrst_ready", s_ready_o, 0);
        chk("midrst_core_reset", core_reset_o, 1);
        chk("midrst_busy", busy_o, 0);
        run_prog(2, 3, 0, 0, 0, 32'h0BAD0020, 2, 3, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int len, da, g, sr, cnt;
            bit dn;
            logic [31:0] rw;
            len = $urandom_range(0, 24);
            g   = $urandom_range(0, 60);
            da  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, T + 20);
            sr  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
            rw  = $urandom;
            dn  = (da != 0) && (da <= T);
            cnt = dn ? da : T;
            run_prog(len, da, 0, g, sr, rw, len, cnt, dn, !dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
